// File: rtl/tlcd_bus_receiver.sv
// HD44780-style text LCD bus receiver: shadows the 2x16 DDRAM, emulates busy timing, flags overruns.
// Optional CGRAM shadow storage enabled by defining TLCD_RX_CGRAM_EN.
module tlcd_bus_receiver #(
   parameter int unsigned BUSY_CYCLES      = 2000,
   parameter int unsigned BUSY_LONG_CYCLES = 82000
) (
   input  logic         CLK,
   input  logic         RESETN,
   input  logic         TLCD_E,
   input  logic         TLCD_RS,
   input  logic         TLCD_RW,
   input  logic [7:0]   TLCD_DATA,
   output logic [127:0] TEXT_STRING_UPPER,
   output logic [127:0] TEXT_STRING_LOWER,
   output logic [6:0]   DDRAM_ADDR,
   output logic         DISPLAY_ON,
   output logic         BUSY,
   output logic         WR_STROBE,
   output logic         OVERRUN,
   input  logic [5:0]   CG_RD_ADDR,
   output logic [4:0]   CG_RD_DATA
);

   localparam int unsigned BUSY_MAX = (BUSY_LONG_CYCLES > BUSY_CYCLES) ? BUSY_LONG_CYCLES
                                                                       : BUSY_CYCLES;
   localparam int unsigned CNT_W    = $clog2(BUSY_MAX + 1);
   localparam logic [127:0] BLANK_ROW = {16{8'h20}};

   logic             e_q, e_prev_q, rs_q, rw_q;
   logic [7:0]       data_q;
   logic [127:0]     upper_q, upper_d, lower_q, lower_d;
   logic [6:0]       ac_q, ac_d;
   logic             inc_q, inc_d;
   logic             cg_mode_q, cg_mode_d;
   logic [5:0]       cg_addr_q, cg_addr_d;
   logic             disp_on_q, disp_on_d;
   logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
   logic             busy_q, busy_d;
   logic             wr_strobe_q, wr_strobe_d;
   logic             overrun_q, overrun_d;
   logic             accept_c, long_c, cg_we_c;
   logic [6:0]       col_lsb_c;

   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
      logic [6:0] nxt;
      if (inc) begin
         case (ac)
            7'h27:   nxt = 7'h40;
            7'h67:   nxt = 7'h00;
            7'h7F:   nxt = 7'h00;
            default: nxt = ac + 7'd1;
         endcase
      end else begin
         case (ac)
            7'h00:   nxt = 7'h67;
            7'h40:   nxt = 7'h27;
            default: nxt = ac - 7'd1;
         endcase
      end
      return nxt;
   endfunction

   // Bus sampling; a write is taken one cycle after E is first seen low
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         e_q      <= 1'b0;
         e_prev_q <= 1'b0;
         rs_q     <= 1'b0;
         rw_q     <= 1'b1;
         data_q   <= 8'h00;
      end else begin
         e_q      <= TLCD_E;
         e_prev_q <= e_q;
         rs_q     <= TLCD_RS;
         rw_q     <= TLCD_RW;
         data_q   <= TLCD_DATA;
      end
   end

   assign accept_c  = e_prev_q & ~e_q & ~rw_q;
   // Column 0 sits in the top byte, so the byte offset is (15 - col)
   assign col_lsb_c = {~ac_q[3:0], 3'b000};

   always_comb begin
      upper_d     = upper_q;
      lower_d     = lower_q;
      ac_d        = ac_q;
      inc_d       = inc_q;
      cg_mode_d   = cg_mode_q;
      cg_addr_d   = cg_addr_q;
      disp_on_d   = disp_on_q;
      overrun_d   = overrun_q;
      wr_strobe_d = 1'b0;
      long_c      = 1'b0;
      cg_we_c     = 1'b0;
      busy_cnt_d  = (busy_cnt_q != '0) ? busy_cnt_q - CNT_W'(1) : busy_cnt_q;

      if (accept_c) begin
         wr_strobe_d = 1'b1;
         if (busy_q) overrun_d = 1'b1;
         if (!rs_q) begin
            casez (data_q)
               8'b1???????: begin ac_d = data_q[6:0]; cg_mode_d = 1'b0; end
               8'b01??????: begin cg_mode_d = 1'b1; cg_addr_d = data_q[5:0]; end
               8'b001?????: ;
               8'b0001????: ;
               8'b00001???: disp_on_d = data_q[2];
               8'b000001??: inc_d = data_q[1];
               8'b0000001?: begin ac_d = 7'h00; cg_mode_d = 1'b0; long_c = 1'b1; end
               8'b00000001: begin
                  upper_d   = BLANK_ROW;
                  lower_d   = BLANK_ROW;
                  ac_d      = 7'h00;
                  inc_d     = 1'b1;
                  cg_mode_d = 1'b0;
                  long_c    = 1'b1;
               end
               default: ;
            endcase
         end else if (cg_mode_q) begin
            cg_we_c   = 1'b1;
            cg_addr_d = inc_q ? cg_addr_q + 6'd1 : cg_addr_q - 6'd1;
         end else begin
            if (ac_q[6:4] == 3'b000) upper_d[col_lsb_c +: 8] = data_q;
            if (ac_q[6:4] == 3'b100) lower_d[col_lsb_c +: 8] = data_q;
            ac_d = ac_step(ac_q, inc_q);
         end
         busy_cnt_d = long_c ? CNT_W'(BUSY_LONG_CYCLES) : CNT_W'(BUSY_CYCLES);
      end
      busy_d = (busy_cnt_d != '0);
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         upper_q     <= BLANK_ROW;
         lower_q     <= BLANK_ROW;
         ac_q        <= 7'h00;
         inc_q       <= 1'b1;
         cg_mode_q   <= 1'b0;
         cg_addr_q   <= 6'h00;
         disp_on_q   <= 1'b0;
         busy_cnt_q  <= '0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         upper_q     <= upper_d;
         lower_q     <= lower_d;
         ac_q        <= ac_d;
         inc_q       <= inc_d;
         cg_mode_q   <= cg_mode_d;
         cg_addr_q   <= cg_addr_d;
         disp_on_q   <= disp_on_d;
         busy_cnt_q  <= busy_cnt_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef TLCD_RX_CGRAM_EN
   logic [4:0] cgram_q [64];

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         for (int i = 0; i < 64; i++) cgram_q[i] <= 5'h00;
      end else if (cg_we_c) begin
         cgram_q[cg_addr_q] <= data_q[4:0];
      end
   end

   assign CG_RD_DATA = cgram_q[CG_RD_ADDR];
`else
   logic unused_cg_c;
   assign unused_cg_c = ^{CG_RD_ADDR, cg_we_c};
   assign CG_RD_DATA  = 5'h00;
`endif

   assign TEXT_STRING_UPPER = upper_q;
   assign TEXT_STRING_LOWER = lower_q;
   assign DDRAM_ADDR        = ac_q;
   assign DISPLAY_ON        = disp_on_q;
   assign BUSY              = busy_q;
   assign WR_STROBE         = wr_strobe_q;
   assign OVERRUN           = overrun_q;

endmodule

// File: tb/tb_tlcd_bus_receiver.sv
// Scoreboard bench for tlcd_bus_receiver: a cell-array model predicts state after every write.
module tb_tlcd_bus_receiver;

   localparam int unsigned BC = 16;
   localparam int unsigned BL = 50;

   logic         CLK = 1'b0;
   logic         RESETN = 1'b0;
   logic         TLCD_E = 1'b0, TLCD_RS = 1'b0, TLCD_RW = 1'b0;
   logic [7:0]   TLCD_DATA = 8'h00;
   logic [5:0]   CG_RD_ADDR = 6'h00;
   logic [127:0] TEXT_STRING_UPPER, TEXT_STRING_LOWER;
   logic [6:0]   DDRAM_ADDR;
   logic         DISPLAY_ON, BUSY, WR_STROBE, OVERRUN;
   logic [4:0]   CG_RD_DATA;

   tlcd_bus_receiver #(.BUSY_CYCLES(BC), .BUSY_LONG_CYCLES(BL)) dut (
      .CLK(CLK), .RESETN(RESETN), .TLCD_E(TLCD_E), .TLCD_RS(TLCD_RS), .TLCD_RW(TLCD_RW),
      .TLCD_DATA(TLCD_DATA), .TEXT_STRING_UPPER(TEXT_STRING_UPPER),
      .TEXT_STRING_LOWER(TEXT_STRING_LOWER), .DDRAM_ADDR(DDRAM_ADDR), .DISPLAY_ON(DISPLAY_ON),
      .BUSY(BUSY), .WR_STROBE(WR_STROBE), .OVERRUN(OVERRUN), .CG_RD_ADDR(CG_RD_ADDR),
      .CG_RD_DATA(CG_RD_DATA));

   always #5 CLK = ~CLK;

   typedef struct {
      logic [127:0] up;
      logic [127:0] lo;
      logic [6:0]   ac;
      logic         disp;
      logic         ovr;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0, fails = 0;
   int   cyc = 0, strobes = 0, busy_run = 0, last_run = 0;

   // Reference state
   logic [7:0] m_cell [32];
   logic [4:0] m_cgram [64];
   logic [6:0] m_ac;
   logic [5:0] m_cga;
   logic       m_inc, m_cg, m_disp, m_ovr;
   int         last_t0 = -1000000, last_len = 0, n_writes = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] row_str(input int r);
      logic [127:0] v;
      for (int c = 0; c < 16; c++) v[127 - 8*c -: 8] = m_cell[r*16 + c];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
      for (int i = 0; i < 64; i++) m_cgram[i] = 5'h00;
      m_ac = 7'h00; m_cga = 6'h00; m_inc = 1'b1; m_cg = 1'b0; m_disp = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic model_write(input logic rs, input logic [7:0] d, input int t0);
      exp_t e;
      logic long_busy = 1'b0;
      int   a;
      if (t0 - last_t0 <= last_len) m_ovr = 1'b1;
      if (!rs) begin
         if (d[7]) begin m_ac = d[6:0]; m_cg = 1'b0; end
         else if (d[6]) begin m_cg = 1'b1; m_cga = d[5:0]; end
         else if (d[5] || d[4]) begin end
         else if (d[3]) m_disp = d[2];
         else if (d[2]) m_inc = d[1];
         else if (d[1]) begin m_ac = 7'h00; m_cg = 1'b0; long_busy = 1'b1; end
         else if (d[0]) begin
            for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
            m_ac = 7'h00; m_inc = 1'b1; m_cg = 1'b0; long_busy = 1'b1;
         end
      end else if (m_cg) begin
         m_cgram[m_cga] = d[4:0];
         m_cga = m_inc ? m_cga + 6'd1 : m_cga - 6'd1;
      end else begin
         a = int'(m_ac);
         if (a < 16) m_cell[a] = d;
         else if (a >= 64 && a < 80) m_cell[a - 48] = d;
         if (m_inc) a = (a == 'h27) ? 'h40 : (a == 'h67 || a == 'h7F) ? 0 : a + 1;
         else       a = (a == 0) ? 'h67 : (a == 'h40) ? 'h27 : a - 1;
         m_ac = 7'(a);
      end
      last_t0  = t0;
      last_len = long_busy ? BL : BC;
      n_writes++;
      e.up = row_str(0); e.lo = row_str(1); e.ac = m_ac; e.disp = m_disp; e.ovr = m_ovr;
      exp_q.push_back(e);
   endtask

   task automatic bus_write(input logic rs, input logic rw, input logic [7:0] d);
      @(posedge CLK); #1;
      TLCD_RS = rs; TLCD_RW = rw; TLCD_DATA = d; TLCD_E = 1'b1;
      if (!rw) model_write(rs, d, cyc);
      repeat (2) @(posedge CLK);
      #1 TLCD_E = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
   endtask

   task automatic wr_idle(input logic rs, input logic [7:0] d);
      bus_write(rs, 1'b0, d);
      repeat (last_len) @(posedge CLK);
   endtask

   // Monitor: pops one prediction per strobe; also measures BUSY run lengths
   always @(negedge CLK) begin
      if (RESETN && WR_STROBE) begin
         strobes++;
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_upper", TEXT_STRING_UPPER, e.up);
            chk("sb_lower", TEXT_STRING_LOWER, e.lo);
            chk("sb_addr", DDRAM_ADDR, e.ac);
            chk("sb_disp", DISPLAY_ON, e.disp);
            chk("sb_overrun", OVERRUN, e.ovr);
         end
      end
      if (BUSY) busy_run++;
      else if (busy_run > 0) begin last_run = busy_run; busy_run = 0; end
   end

   initial begin
      repeat (60000) @(posedge CLK);
      $display("FAIL watchdog: got no finish by cycle %0d expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      logic [4:0] cexp;
      model_reset();
      repeat (3) @(posedge CLK);
      #1 TLCD_E = 1'b1;
      @(posedge CLK); #1 RESETN = 1'b1;
      @(posedge CLK); #1 RESETN = 1'b0;
      @(posedge CLK); #1 TLCD_E = 1'b0;
      @(posedge CLK); #1 RESETN = 1'b1;
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      chk("rst_upper", TEXT_STRING_UPPER, {16{8'h20}});
      chk("rst_lower", TEXT_STRING_LOWER, {16{8'h20}});
      chk("rst_addr", DDRAM_ADDR, 7'h00);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_disp", DISPLAY_ON, 1'b0);
      chk("rst_overrun", OVERRUN, 1'b0);
      chk("rst_strobes", strobes, 0);

      s0 = strobes;
      wr_idle(1'b0, 8'h80);
      wr_idle(1'b1, 8'h41);
      wr_idle(1'b1, 8'h42);
      #1;
      chk("ab_upper", TEXT_STRING_UPPER[127:112], 16'h4142);
      chk("ab_addr", DDRAM_ADDR, 7'h02);
      chk("ab_strobes", strobes - s0, 3);
      chk("ab_overrun", OVERRUN, 1'b0);

      wr_idle(1'b0, 8'hA7);
      wr_idle(1'b1, 8'h58);
      #1 chk("wrap_addr", DDRAM_ADDR, 7'h40);
      wr_idle(1'b1, 8'h00);
      #1 chk("row1_col0", TEXT_STRING_LOWER[127:120], 8'h00);

      wr_idle(1'b0, 8'h01);
      repeat (5) @(posedge CLK);
      #1;
      chk("clr_upper", TEXT_STRING_UPPER, {16{8'h20}});
      chk("clr_lower", TEXT_STRING_LOWER, {16{8'h20}});
      chk("clr_addr", DDRAM_ADDR, 7'h00);
      chk("long_busy_len", last_run, BL);

      for (int i = 0; i < 40; i++) begin
         logic       rs, rw;
         logic [7:0] d;
         rw = ($urandom_range(0, 9) == 0);
         rs = 1'($urandom_range(0, 1));
         d  = 8'($urandom);
         if (!rs) begin
            case ($urandom_range(0, 6))
               0: d = 8'h80 | 8'($urandom_range(0, 127));
               1: d = 8'h80 | 8'($urandom_range(0, 15));
               2: d = 8'hC0 | 8'($urandom_range(0, 15));
               3: d = 8'h40 | 8'($urandom_range(0, 63));
               4: d = 8'h04 | 8'($urandom_range(0, 3));
               5: d = 8'h08 | 8'($urandom_range(0, 7));
               default: d = 8'($urandom_range(0, 63));
            endcase
         end
         if (rw) begin bus_write(rs, 1'b1, d); repeat (2) @(posedge CLK); end
         else wr_idle(rs, d);
      end
      #1 chk("rand_overrun", OVERRUN, 1'b0);
      chk("rand_strobes", strobes, n_writes);

      bus_write(1'b0, 1'b0, 8'h01);
      bus_write(1'b1, 1'b0, 8'h5A);
      repeat (BL + 5) @(posedge CLK);
      #1 chk("overrun_set", OVERRUN, 1'b1);

      wr_idle(1'b0, 8'h04);
      wr_idle(1'b0, 8'h80);
      wr_idle(1'b1, 8'h30);
      #1;
      chk("dec_upper", TEXT_STRING_UPPER[127:120], 8'h30);
      chk("dec_addr", DDRAM_ADDR, 7'h67);
      s0 = strobes;
      bus_write(1'b1, 1'b1, 8'h77);
      repeat (4) @(posedge CLK);
      #1;
      chk("read_strobes", strobes - s0, 0);
      chk("read_addr", DDRAM_ADDR, 7'h67);

      wr_idle(1'b0, 8'h06);
      wr_idle(1'b0, 8'h40);
      for (int i = 0; i < 8; i++) wr_idle(1'b1, 8'h1F);
      wr_idle(1'b0, 8'h80);
      #1;
      chk("cg_upper", TEXT_STRING_UPPER, row_str(0));
      chk("cg_lower", TEXT_STRING_LOWER, row_str(1));
      for (int a = 0; a < 9; a++) begin
         CG_RD_ADDR = 6'(a);
         #1;
`ifdef TLCD_RX_CGRAM_EN
         cexp = m_cgram[a];
         if (a < 8) chk("cg_model_row", m_cgram[a], 5'h1F);
`else
         cexp = 5'h00;
`endif
         chk("cg_rd_data", CG_RD_DATA, cexp);
      end

      repeat (5) @(posedge CLK);
      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
